// File: rtl/fft_pkg.sv
// Shared FFT package: read-side FSM states, FFT size helper and bit reversal.
// Also used by the twiddle-ROM index math.
package fft_pkg;

    // States of the reorder buffer read FSM
    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_DRAIN = 1'b1
    } rd_state_t;

    // Number of points for a given log2 FFT size
    function automatic int unsigned fft_size(input int unsigned log2_n);
        return 32'd1 << log2_n;
    endfunction

    // Reverse the low log2_n bits of value; the upper bits of the result are zero
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned log2_n);
        logic [31:0] r;
        r = '0;
        for (int unsigned b = 0; b < log2_n; b++) begin
            r[b] = value[log2_n - 1 - b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
module fft_sdp_ram #(
    parameter int AW = 9,
    parameter int DW = 24
) (
    input  logic          mclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Write port and synchronous read port
    always_ff @(posedge mclk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames into natural order using two ping-pong banks.
// Optional macro FFT_REORDER_BIN_IDX_EN adds o_bin, the natural bin index of each output.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int W      = 12,
    parameter int LOG2_N = 8
) (
    input  logic              mclk,
    input  logic              i_init_n,
    input  logic              i_vld,
    input  logic [W-1:0]      i_I,
    input  logic [W-1:0]      i_Q,
    output logic              o_vld,
    output logic [W-1:0]      o_I,
    output logic [W-1:0]      o_Q,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_ovf_strb
`ifdef FFT_REORDER_BIN_IDX_EN
    ,
    output logic [LOG2_N-1:0] o_bin
`endif
);

    localparam int N  = int'(fft_size(LOG2_N));
    localparam int AW = LOG2_N + 1;

    logic [LOG2_N-1:0] wr_cnt;
    logic              wr_bank;
    logic [1:0]        full;
    logic              wr_en;
    logic              wr_last;
    logic [1:0]        set_full;
    logic [1:0]        clr_full;
    logic [LOG2_N-1:0] wr_addr_lo;

    rd_state_t         state, state_nxt;
    logic [LOG2_N-1:0] rd_cnt, rd_cnt_nxt;
    logic              rd_bank, rd_bank_nxt;
    logic              rd_en;
    logic [LOG2_N-1:0] rd_idx;

    logic              rd_vld_q;
    logic [LOG2_N-1:0] rd_idx_q;
    logic [2*W-1:0]    rd_data;

    // Write-side decode: accept unless the target bank still holds an undrained frame
    always_comb begin
        wr_en      = i_vld & ~full[wr_bank];
        wr_last    = wr_en & (wr_cnt == LOG2_N'(N - 1));
        set_full   = '0;
        if (wr_last) begin
            set_full[wr_bank] = 1'b1;
        end
        wr_addr_lo = LOG2_N'(bitrev(32'(wr_cnt), LOG2_N));
    end

    // Write counter, bank pointer and overflow strobe
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            wr_cnt     <= '0;
            wr_bank    <= 1'b0;
            o_ovf_strb <= 1'b0;
        end else begin
            o_ovf_strb <= i_vld & full[wr_bank];
            if (wr_en) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt  <= wr_cnt + LOG2_N'(1);
                end
            end
        end
    end

    // Bank full flags: write completion sets, end of drain clears (never the same bank)
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            full <= '0;
        end else begin
            full <= (full & ~clr_full) | set_full;
        end
    end

    // Read FSM next-state: IDLE issues address 0 itself, so DRAIN continues from 1.
    // A bank completing in the same cycle as the drain end keeps frames gapless.
    always_comb begin
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        rd_en       = 1'b0;
        rd_idx      = rd_cnt;
        clr_full    = '0;
        case (state)
            RD_IDLE: begin
                if (full[rd_bank]) begin
                    rd_en      = 1'b1;
                    rd_idx     = '0;
                    rd_cnt_nxt = LOG2_N'(1);
                    state_nxt  = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                rd_en      = 1'b1;
                rd_cnt_nxt = rd_cnt + LOG2_N'(1);
                if (rd_cnt == LOG2_N'(N - 1)) begin
                    clr_full[rd_bank] = 1'b1;
                    rd_bank_nxt       = ~rd_bank;
                    rd_cnt_nxt        = '0;
                    if (!(full[~rd_bank] | set_full[~rd_bank])) begin
                        state_nxt = RD_IDLE;
                    end
                end
            end
            default: state_nxt = RD_IDLE;
        endcase
    end

    // Read FSM state register
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            state   <= RD_IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    fft_sdp_ram #(
        .AW (AW),
        .DW (2 * W)
    ) u_ram (
        .mclk  (mclk),
        .we    (wr_en),
        .waddr ({wr_bank, wr_addr_lo}),
        .wdata ({i_I, i_Q}),
        .re    (rd_en),
        .raddr ({rd_bank, rd_idx}),
        .rdata (rd_data)
    );

    // Track which reads are in flight alongside the RAM read latency
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            rd_vld_q <= 1'b0;
            rd_idx_q <= '0;
        end else begin
            rd_vld_q <= rd_en;
            rd_idx_q <= rd_idx;
        end
    end

    // Output register: data, valid and frame flags
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            o_vld <= 1'b0;
            o_sof <= 1'b0;
            o_eof <= 1'b0;
            o_I   <= '0;
            o_Q   <= '0;
        end else begin
            o_vld <= rd_vld_q;
            o_sof <= rd_vld_q & (rd_idx_q == '0);
            o_eof <= rd_vld_q & (rd_idx_q == '1);
            if (rd_vld_q) begin
                o_I <= rd_data[2*W-1:W];
                o_Q <= rd_data[W-1:0];
            end
        end
    end

`ifdef FFT_REORDER_BIN_IDX_EN
    // Natural bin index of the current output sample
    always_ff @(posedge mclk) begin
        if (!i_init_n) begin
            o_bin <= '0;
        end else if (rd_vld_q) begin
            o_bin <= rd_idx_q;
        end
    end
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder (N=8, W=12) with a frame-level reference model.
module tb_fft_bitrev_reorder;

    localparam int W      = 12;
    localparam int LOG2_N = 3;
    localparam int N      = 8;

    logic              mclk;
    logic              i_init_n;
    logic              i_vld;
    logic [W-1:0]      i_I;
    logic [W-1:0]      i_Q;
    logic              o_vld;
    logic [W-1:0]      o_I;
    logic [W-1:0]      o_Q;
    logic              o_sof;
    logic              o_eof;
    logic              o_ovf_strb;
`ifdef FFT_REORDER_BIN_IDX_EN
    logic [LOG2_N-1:0] o_bin;
`endif

    fft_bitrev_reorder #(
        .W      (W),
        .LOG2_N (LOG2_N)
    ) dut (
        .mclk       (mclk),
        .i_init_n   (i_init_n),
        .i_vld      (i_vld),
        .i_I        (i_I),
        .i_Q        (i_Q),
        .o_vld      (o_vld),
        .o_I        (o_I),
        .o_Q        (o_Q),
        .o_sof      (o_sof),
        .o_eof      (o_eof),
        .o_ovf_strb (o_ovf_strb)
`ifdef FFT_REORDER_BIN_IDX_EN
        ,
        .o_bin      (o_bin)
`endif
    );

    typedef struct {
        logic [W-1:0] i;
        logic [W-1:0] q;
        int unsigned  idx;
    } exp_t;

    exp_t         exp_q[$];
    int unsigned  lat_q[$];
    int unsigned  cyc;
    int unsigned  n_cmp;
    int unsigned  n_bad;
    bit           in_frame;
    bit           ignore_out;
    logic [W-1:0] nat_i [N];
    logic [W-1:0] nat_q [N];

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference bit reversal by repeated halving
    function automatic int unsigned rev_ref(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = v;
        for (int b = 0; b < LOG2_N; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    // Feed the frame held in nat_i/nat_q in bit-reversed order.
    // mode 0: continuous, 1: alternating gaps, 2: random gaps
    task automatic send_frame(input int mode);
        exp_t e;
        for (int p = 0; p < N; p++) begin
            int unsigned k = rev_ref(p);
            i_vld = 1'b1;
            i_I   = nat_i[k];
            i_Q   = nat_q[k];
            tick();
            i_vld = 1'b0;
            i_I   = $urandom;
            i_Q   = $urandom;
            if (p == N - 1) begin
                lat_q.push_back(cyc);
                for (int n = 0; n < N; n++) begin
                    e.i   = nat_i[n];
                    e.q   = nat_q[n];
                    e.idx = n;
                    exp_q.push_back(e);
                end
            end else if (mode == 1) begin
                tick();
            end else if (mode == 2) begin
                repeat ($urandom_range(0, 2)) tick();
            end
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int n = 0; n < N; n++) begin
            nat_i[n] = W'(base + n);
            nat_q[n] = W'(-(base + n));
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < N; n++) begin
            nat_i[n] = W'($urandom);
            nat_q[n] = W'($urandom);
        end
    endtask

    task automatic wait_drain();
        int unsigned budget = 200;
        while ((exp_q.size() != 0 || in_frame) && budget != 0) begin
            tick();
            budget--;
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (2) tick();
    endtask

    task automatic do_reset();
        i_init_n = 1'b0;
        i_vld    = 1'b0;
        tick();
        exp_q.delete();
        lat_q.delete();
        in_frame = 1'b0;
        chk("rst_vld", 32'(o_vld), 0);
        chk("rst_sof", 32'(o_sof), 0);
        chk("rst_eof", 32'(o_eof), 0);
        chk("rst_ovf", 32'(o_ovf_strb), 0);
        chk("rst_I", 32'(o_I), 0);
        chk("rst_Q", 32'(o_Q), 0);
`ifdef FFT_REORDER_BIN_IDX_EN
        chk("rst_bin", 32'(o_bin), 0);
`endif
        i_init_n = 1'b1;
    endtask

    // Output monitor: every valid output must match the head of the expected stream
    always @(negedge mclk) begin
        if (i_init_n && !ignore_out) begin
            chk("ovf_quiet", 32'(o_ovf_strb), 0);
            if (o_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_vld", 32'(o_vld), 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_I", 32'(o_I), 32'(e.i));
                    chk("out_Q", 32'(o_Q), 32'(e.q));
                    chk("out_sof", 32'(o_sof), 32'(e.idx == 0));
                    chk("out_eof", 32'(o_eof), 32'(e.idx == N - 1));
`ifdef FFT_REORDER_BIN_IDX_EN
                    chk("out_bin", 32'(o_bin), e.idx);
`endif
                    if (e.idx == 0 && lat_q.size() != 0) begin
                        int unsigned last_wr;
                        last_wr = lat_q.pop_front();
                        chk("latency", cyc - last_wr, 2);
                    end
                    in_frame = (e.idx != N - 1);
                end
            end else if (in_frame) begin
                chk("gap_in_frame", 32'(o_vld), 1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        in_frame   = 1'b0;
        ignore_out = 1'b0;
        i_init_n   = 1'b0;
        i_vld      = 1'b0;
        i_I        = '0;
        i_Q        = '0;
        repeat (2) tick();
        do_reset();

        // Ordering with a ramp, then alternating gaps
        fill_ramp(0);
        send_frame(0);
        wait_drain();
        fill_ramp(0);
        send_frame(1);
        wait_drain();

        // Three back-to-back frames, I = 8f + index
        for (int f = 0; f < 3; f++) begin
            fill_ramp(8 * f);
            send_frame(0);
        end
        wait_drain();

        // Random data, mixed gap patterns, some back-to-back
        for (int r = 0; r < 6; r++) begin
            fill_random();
            send_frame(r % 3);
            if (r % 2 == 1) wait_drain();
        end
        wait_drain();

        // Reset in the middle of a write frame
        fill_random();
        for (int p = 0; p < 5; p++) begin
            i_vld = 1'b1;
            i_I   = W'($urandom);
            i_Q   = W'($urandom);
            tick();
        end
        do_reset();
        fill_random();
        send_frame(0);
        wait_drain();

        // Reset while output index 3 is on the bus
        fill_random();
        send_frame(0);
        repeat (5) tick();
        do_reset();
        chk("full_after_rst", 32'(dut.full), 0);
        repeat (3) tick();
        fill_random();
        send_frame(2);
        wait_drain();

        // Overflow: both banks forced full, then a sample arrives
        for (int p = 0; p < 3; p++) begin
            i_vld = 1'b1;
            i_I   = W'($urandom);
            i_Q   = W'($urandom);
            tick();
        end
        ignore_out = 1'b1;
        force dut.full = 2'b11;
        i_vld = 1'b1;
        tick();
        chk("ovf_pulse", 32'(o_ovf_strb), 1);
        chk("ovf_wr_hold", 32'(dut.wr_cnt), 3);
        i_vld = 1'b0;
        tick();
        chk("ovf_one_cycle", 32'(o_ovf_strb), 0);
        release dut.full;
        do_reset();
        ignore_out = 1'b0;

        // Clean frame after the overflow recovery
        fill_random();
        send_frame(0);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
